pipelined_alu_param: RTL and testbench
======================================

Name: pipelined_alu_param

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Covers ADD/SUB/AND/OR plus XOR, an accumulator mode and an explicit illegal-opcode flag; illegal opcodes no longer drive the result to high-Z.
- One-deep output register with valid/ready handshakes on both sides, so it sits between the operand-fetch stage and the writeback/display stage.
- Carry and overflow are produced by the same single-width adder for ADD, SUB and ACC; there are no separate add/sub flag outputs.

Parameters:
- WIDTH, 4: operand, result and accumulator width in bits; legal range 2..32.
- ACC_EN, 1: when 0, opcodes 101 and 110 are treated as illegal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode bundle present.
- in_ready  out  1  block can accept a bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for ADD/ACC, borrow-in for SUB.
- op  in  3  opcode.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- cout  out  1  carry out (ADD/ACC) or no-borrow (SUB); 0 for logic ops.
- ovf  out  1  signed two's-complement overflow; 0 for logic ops.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- err  out  1  illegal opcode accepted; result forced to 0.
- acc_out  out  WIDTH  current accumulator value.

Behaviour:
- Reset (async, any time, including mid-transfer): out_valid=0, result=0, cout=0, ovf=0, zero=0, neg=0, err=0, accumulator=0, acc_out=0.
- After reset, in_ready=1.
- Any held result is discarded on reset and never reappears.
- in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at a rising edge.
  - Registers result and all flags.
  - Sets out_valid=1.
  - Latency is 1 cycle from accept to out_valid.
- out_valid && out_ready with no accept: out_valid clears next edge.
- Simultaneous consume and accept: the new result replaces the old one, out_valid stays 1, and full throughput is one per cycle.
- Stall (out_valid && !out_ready): result, flags and acc_out are held stable. Inputs are ignored.
- Opcodes (all sums computed in WIDTH+1 bits; result is the low WIDTH bits):
  - 000 ADD: a+b+cin. cout = bit WIDTH of the sum.
  - 001 SUB: a+~b+!cin, i.e. a-b-cin. cout=1 means no borrow.
  - 010 AND: a&b.
  - 011 OR: a|b.
  - 100 XOR: a^b.
  - 101 ACC: acc+a+cin. The accumulator and result both take the new value; cout as for ADD.
  - 110 CLRACC: accumulator=0, result=0.
  - 111, or 101/110 when ACC_EN=0: result=0, err=1, accumulator unchanged.
- Flag rules:
  - ovf for ADD/ACC = (x[MSB]==y[MSB]) && (sum[MSB]!=x[MSB]), with x=a (or acc) and y=b (or a).
  - ovf for SUB = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - Logic ops, CLRACC and illegal opcodes: cout=0, ovf=0.
  - zero and neg are derived from the registered result for every opcode.
  - err=0 for every legal opcode.
- The accumulator only changes on an accepted ACC or CLRACC, never during a stall.
- Wrap-around is modular 2^WIDTH; cout/ovf report it and there is no saturation.
- Inputs with X while in_valid=0 must not affect state.

Test Plan:
- WIDTH=4: reset pulse mid-stall (out_valid=1, out_ready=0) -> next cycle out_valid=0, result=0, acc_out=0, in_ready=1.
- WIDTH=4: ADD a=0111 b=0001 cin=0 -> result 1000, cout 0, ovf 1, neg 1, zero 0, one cycle after accept.
- WIDTH=4: SUB a=0011 b=0101 cin=0 -> result 1110, cout 0 (borrow), ovf 0, neg 1. Then SUB a=0101 b=0101 cin=0 -> result 0000, cout 1, zero 1.
- WIDTH=4: ACC a=1001 ×2 from acc=0, cin=0 -> acc_out 1001 then 0010, cout 1 on the second. Then CLRACC -> acc_out 0000, zero 1.
- WIDTH=4: op=111 -> err 1, result 0000, acc unchanged. Repeat with ACC_EN=0 and op=101 -> err 1, acc_out stays 0000.
- WIDTH=8 back-to-back stream of 4 ops with out_ready toggling 1,0,1,1 -> in_ready low exactly in the stalled cycle, no result lost or duplicated, results appear in order. Example: AND 0xF0&0x3C=0x30, XOR 0xFF^0x0F=0xF0.

Source files
------------

// File: rtl/pipelined_alu_param.sv
// ============================================================================
// Module   : pipelined_alu_param
// Purpose  : Registered ALU (ADD/SUB/AND/OR/XOR/ACC/CLRACC) behind a
//            one-deep valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_alu_param #(
   parameter int WIDTH  = 4,
   parameter bit ACC_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic             err,
   output logic [WIDTH-1:0] acc_out
);

   localparam logic [2:0] c_op_add = 3'b000;
   localparam logic [2:0] c_op_sub = 3'b001;
   localparam logic [2:0] c_op_and = 3'b010;
   localparam logic [2:0] c_op_or  = 3'b011;
   localparam logic [2:0] c_op_xor = 3'b100;
   localparam logic [2:0] c_op_acc = 3'b101;
   localparam logic [2:0] c_op_clr = 3'b110;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_err;
   logic [WIDTH-1:0] r_acc;

   logic             w_in_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_c;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_arith;
   logic             w_err;
   logic             w_acc_wr;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_cout;
   logic             w_ovf;

   assign w_in_ready = !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;

   // One shared adder: SUB feeds ~b with inverted borrow, ACC feeds acc+a.
   always_comb begin
      w_x = a;
      w_y = b;
      w_c = cin;
      if (op == c_op_sub) begin
         w_y = ~b;
         w_c = !cin;
      end else if (op == c_op_acc) begin
         w_x = r_acc;
         w_y = a;
      end
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_c};

   always_comb begin
      w_res     = '0;
      w_arith   = 1'b0;
      w_err     = 1'b0;
      w_acc_wr  = 1'b0;
      w_acc_nxt = r_acc;
      case (op)
         c_op_add, c_op_sub: begin
            w_res   = w_sum[WIDTH-1:0];
            w_arith = 1'b1;
         end
         c_op_and: w_res = a & b;
         c_op_or:  w_res = a | b;
         c_op_xor: w_res = a ^ b;
         c_op_acc: begin
            if (ACC_EN) begin
               w_res     = w_sum[WIDTH-1:0];
               w_arith   = 1'b1;
               w_acc_wr  = 1'b1;
               w_acc_nxt = w_sum[WIDTH-1:0];
            end else begin
               w_err = 1'b1;
            end
         end
         c_op_clr: begin
            if (ACC_EN) begin
               w_acc_wr  = 1'b1;
               w_acc_nxt = '0;
            end else begin
               w_err = 1'b1;
            end
         end
         default: w_err = 1'b1;
      endcase
   end

   assign w_cout = w_arith && w_sum[WIDTH];
   assign w_ovf  = w_arith && (w_x[WIDTH-1] == w_y[WIDTH-1])
                           && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
         r_err       <= 1'b0;
         r_acc       <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
            r_zero      <= (w_res == '0);
            r_err       <= w_err;
            if (w_acc_wr) begin
               r_acc <= w_acc_nxt;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;
   assign neg       = r_result[WIDTH-1];
   assign err       = r_err;
   assign acc_out   = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_alu_param.sv
// ============================================================================
// Module   : tb_pipelined_alu_param
// Purpose  : Directed self-checking bench for pipelined_alu_param (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_alu_param;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   // s4: WIDTH=4 ACC_EN=1, n4: WIDTH=4 ACC_EN=0, s8: WIDTH=8 ACC_EN=1
   logic       s4_iv, s4_ir, s4_cin, s4_ov, s4_or, s4_cout, s4_ovf, s4_zero, s4_neg, s4_err;
   logic [3:0] s4_a, s4_b, s4_res, s4_acc;
   logic [2:0] s4_op;
   logic       n4_iv, n4_ir, n4_cin, n4_ov, n4_or, n4_cout, n4_ovf, n4_zero, n4_neg, n4_err;
   logic [3:0] n4_a, n4_b, n4_res, n4_acc;
   logic [2:0] n4_op;
   logic       s8_iv, s8_ir, s8_cin, s8_ov, s8_or, s8_cout, s8_ovf, s8_zero, s8_neg, s8_err;
   logic [7:0] s8_a, s8_b, s8_res, s8_acc;
   logic [2:0] s8_op;

   pipelined_alu_param #(.WIDTH(4), .ACC_EN(1'b1)) u_s4 (
      .clk(clk), .reset(reset), .in_valid(s4_iv), .in_ready(s4_ir), .a(s4_a), .b(s4_b),
      .cin(s4_cin), .op(s4_op), .out_valid(s4_ov), .out_ready(s4_or), .result(s4_res),
      .cout(s4_cout), .ovf(s4_ovf), .zero(s4_zero), .neg(s4_neg), .err(s4_err), .acc_out(s4_acc));

   pipelined_alu_param #(.WIDTH(4), .ACC_EN(1'b0)) u_n4 (
      .clk(clk), .reset(reset), .in_valid(n4_iv), .in_ready(n4_ir), .a(n4_a), .b(n4_b),
      .cin(n4_cin), .op(n4_op), .out_valid(n4_ov), .out_ready(n4_or), .result(n4_res),
      .cout(n4_cout), .ovf(n4_ovf), .zero(n4_zero), .neg(n4_neg), .err(n4_err), .acc_out(n4_acc));

   pipelined_alu_param #(.WIDTH(8), .ACC_EN(1'b1)) u_s8 (
      .clk(clk), .reset(reset), .in_valid(s8_iv), .in_ready(s8_ir), .a(s8_a), .b(s8_b),
      .cin(s8_cin), .op(s8_op), .out_valid(s8_ov), .out_ready(s8_or), .result(s8_res),
      .cout(s8_cout), .ovf(s8_ovf), .zero(s8_zero), .neg(s8_neg), .err(s8_err), .acc_out(s8_acc));

   // Observation vector: {out_valid, result, cout, ovf, zero, neg, err, acc_out}
   function automatic logic [13:0] obs4_s();
      return {s4_ov, s4_res, s4_cout, s4_ovf, s4_zero, s4_neg, s4_err, s4_acc};
   endfunction

   function automatic logic [13:0] obs4_n();
      return {n4_ov, n4_res, n4_cout, n4_ovf, n4_zero, n4_neg, n4_err, n4_acc};
   endfunction

   // One accepted transfer on s4 with the consumer ready; returns just after the edge.
   task automatic drive_s4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic c);
      s4_iv = 1'b1; s4_op = op; s4_a = a; s4_b = b; s4_cin = c; s4_or = 1'b1;
      @(posedge clk); #1;
      s4_iv = 1'b0; s4_a = 'x; s4_b = 'x; s4_op = 'x; s4_cin = 1'bx;
   endtask

   task automatic drive_n4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic c);
      n4_iv = 1'b1; n4_op = op; n4_a = a; n4_b = b; n4_cin = c; n4_or = 1'b1;
      @(posedge clk); #1;
      n4_iv = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] exp_v;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_v = 14'b0;
      if (obs4_s() !== exp_v || s4_ir !== 1'b1) begin
         n_bad++; $display("FAIL reset_s4: got %b ir=%b, want %b ir=1", obs4_s(), s4_ir, exp_v);
      end
      n_cmp++;
      if ({s8_ov, s8_res, s8_cout, s8_ovf, s8_zero, s8_neg, s8_err, s8_acc, s8_ir} !== 23'h1) begin
         n_bad++; $display("FAIL reset_s8: got %h, want 000001", {s8_ov, s8_res, s8_cout, s8_ovf, s8_zero, s8_neg, s8_err, s8_acc, s8_ir});
      end
      n_cmp++;
      reset = 1'b0;
      // Accept ACC 3 but hold the consumer off, then reset mid-stall.
      s4_iv = 1'b1; s4_op = 3'b101; s4_a = 4'b0011; s4_b = 4'b0000; s4_cin = 1'b0; s4_or = 1'b0;
      @(posedge clk); #1;
      s4_iv = 1'b0;
      exp_v = {1'b1, 4'b0011, 5'b00000, 4'b0011};
      if (obs4_s() !== exp_v || s4_ir !== 1'b0) begin
         n_bad++; $display("FAIL prestall: got %b ir=%b, want %b ir=0", obs4_s(), s4_ir, exp_v);
      end
      n_cmp++;
      #2 reset = 1'b1;
      #1;
      if (obs4_s() !== 14'b0) begin
         n_bad++; $display("FAIL async_reset: got %b, want all zero", obs4_s());
      end
      n_cmp++;
      #1 reset = 1'b0;
      @(posedge clk); #1;
      if (obs4_s() !== 14'b0 || s4_ir !== 1'b1) begin
         n_bad++; $display("FAIL post_reset: got %b ir=%b, want 0 ir=1", obs4_s(), s4_ir);
      end
      n_cmp++;
      s4_or = 1'b1;
   endtask

   task automatic test_arith4();
      logic [3:0]  va [6] = '{4'b0111, 4'b0011, 4'b0101, 4'b1010, 4'b1111, 4'b0101};
      logic [3:0]  vb [6] = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0010};
      logic [2:0]  vo [6] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b000, 3'b001};
      logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [13:0] ve [6] = '{
         {1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000},   // 7+1 overflows
         {1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000},   // 3-5 borrows
         {1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000},   // 5-5 = 0
         {1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000},   // OR
         {1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000},   // 15+0+1 wraps
         {1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}};  // 5-2-1
      for (int i = 0; i < 6; i++) begin
         drive_s4(vo[i], va[i], vb[i], vc[i]);
         if (obs4_s() !== ve[i]) begin
            n_bad++; $display("FAIL arith4[%0d]: got %b, want %b", i, obs4_s(), ve[i]);
         end
         n_cmp++;
      end
      @(posedge clk); #1;
      if (s4_ov !== 1'b0) begin
         n_bad++; $display("FAIL drain4: out_valid=%b, want 0", s4_ov);
      end
      n_cmp++;
   endtask

   task automatic test_stall();
      logic [13:0] held;
      s4_iv = 1'b1; s4_op = 3'b000; s4_a = 4'b0111; s4_b = 4'b0001; s4_cin = 1'b0; s4_or = 1'b0;
      @(posedge clk); #1;
      // Offer an ACC while stalled: it must not be taken nor move the accumulator.
      s4_op = 3'b101; s4_a = 4'b0101; s4_cin = 1'b0;
      held = {1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if (obs4_s() !== held || s4_ir !== 1'b0) begin
            n_bad++; $display("FAIL stall[%0d]: got %b ir=%b, want %b ir=0", i, obs4_s(), s4_ir, held);
         end
         n_cmp++;
      end
      s4_or = 1'b1;
      @(posedge clk); #1;
      s4_iv = 1'b0;
      if (obs4_s() !== {1'b1, 4'b0101, 5'b00000, 4'b0101}) begin
         n_bad++; $display("FAIL swap: got %b, want 10101000000101", obs4_s());
      end
      n_cmp++;
      @(posedge clk); #1;
      if (obs4_s() !== {1'b0, 4'b0101, 5'b00000, 4'b0101}) begin
         n_bad++; $display("FAIL consume: got %b, want 00101000000101", obs4_s());
      end
      n_cmp++;
   endtask

   task automatic test_acc();
      logic [2:0]  vo [4] = '{3'b110, 3'b101, 3'b101, 3'b110};
      logic [13:0] ve [4] = '{
         {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000},
         {1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001},
         {1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010},
         {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000}};
      for (int i = 0; i < 4; i++) begin
         drive_s4(vo[i], 4'b1001, 4'b0000, 1'b0);
         if (obs4_s() !== ve[i]) begin
            n_bad++; $display("FAIL acc[%0d]: got %b, want %b", i, obs4_s(), ve[i]);
         end
         n_cmp++;
      end
   endtask

   task automatic test_illegal();
      drive_s4(3'b101, 4'b0011, 4'b0000, 1'b0);
      drive_s4(3'b111, 4'b1111, 4'b1111, 1'b1);
      if (obs4_s() !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011}) begin
         n_bad++; $display("FAIL illegal111: got %b, want 10000001010011", obs4_s());
      end
      n_cmp++;
      drive_n4(3'b101, 4'b0011, 4'b0000, 1'b0);
      if (obs4_n() !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
         n_bad++; $display("FAIL noacc_acc: got %b, want 10000001010000", obs4_n());
      end
      n_cmp++;
      drive_n4(3'b000, 4'b0010, 4'b0011, 1'b0);
      if (obs4_n() !== {1'b1, 4'b0101, 5'b00000, 4'b0000}) begin
         n_bad++; $display("FAIL noacc_add: got %b, want 10101000000000", obs4_n());
      end
      n_cmp++;
      drive_n4(3'b110, 4'b0000, 4'b0000, 1'b0);
      if (obs4_n() !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
         n_bad++; $display("FAIL noacc_clr: got %b, want 10000001010000", obs4_n());
      end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      logic [2:0] vo [4] = '{3'b010, 3'b100, 3'b000, 3'b001};
      logic [7:0] va [4] = '{8'hF0, 8'hFF, 8'h7F, 8'h10};
      logic [7:0] vb [4] = '{8'h3C, 8'h0F, 8'h01, 8'h01};
      logic [9:0] ve [4] = '{{8'h30, 2'b00}, {8'hF0, 2'b00}, {8'h80, 2'b01}, {8'h0F, 2'b10}};
      logic       orp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic       irp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
         s8_or = (cyc < 4) ? orp[cyc] : 1'b1;
         s8_iv = (sent < 4);
         if (sent < 4) begin
            s8_op = vo[sent]; s8_a = va[sent]; s8_b = vb[sent]; s8_cin = 1'b0;
         end
         #1;
         if (cyc < 6) begin
            if (s8_ir !== irp[cyc]) begin
               n_bad++; $display("FAIL b2b_ready[%0d]: got %b, want %b", cyc, s8_ir, irp[cyc]);
            end
            n_cmp++;
         end
         if (s8_ov && s8_or) begin
            if ({s8_res, s8_cout, s8_ovf} !== ve[got]) begin
               n_bad++; $display("FAIL b2b_out[%0d]: got %h, want %h", got, {s8_res, s8_cout, s8_ovf}, ve[got]);
            end
            n_cmp++;
            got++;
         end
         if (s8_iv && s8_ir) sent++;
         @(posedge clk); #1;
      end
      s8_iv = 1'b0;
      #1;
      if (got !== 4 || sent !== 4 || s8_ov !== 1'b0) begin
         n_bad++; $display("FAIL b2b_count: got=%0d sent=%0d ov=%b, want 4 4 0", got, sent, s8_ov);
      end
      n_cmp++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      s4_iv = 1'b0; s4_or = 1'b1; s4_a = '0; s4_b = '0; s4_cin = 1'b0; s4_op = '0;
      n4_iv = 1'b0; n4_or = 1'b1; n4_a = '0; n4_b = '0; n4_cin = 1'b0; n4_op = '0;
      s8_iv = 1'b0; s8_or = 1'b1; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_op = '0;
      test_reset();
      test_arith4();
      test_stall();
      test_acc();
      test_illegal();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
